// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: level count, per-level word
// count, stage-register placement and end-to-end latency.
package adder_tree_pkg;

  // Number of tree levels; a single input still occupies one (pass-through) level.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Words present after `level` pairwise reductions (level 0 = inputs).
  function automatic int words_at_level(input int nb_in, input int level);
    int n;
    n = nb_in;
    for (int i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Cycles from data_in_en to data_out_en.
  function automatic int tree_latency(input int nb_in, input int stride);
    int levels;
    levels = clog2_min1(nb_in);
    if (stride <= 0) return 1;
    return (levels + stride - 1) / stride;
  endfunction

  // A level is registered on every stride boundary, and the last level always is.
  function automatic bit level_is_reg(input int level, input int stride, input int levels);
    return ((stride > 0) && ((level % stride) == 0)) || (level == levels);
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One level of the adder tree: N_IN words in, ceil(N_IN/2) pairwise sums out.
// An unpaired last word passes straight through. REG=1 puts a valid-gated
// register bank behind the adders; REG=0 leaves the level combinational.
module adder_tree_level #(
  parameter int N_IN  = 2,
  parameter int W     = 16,
  parameter int REG   = 1,
  parameter int N_OUT = (N_IN + 1) / 2
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 sclr,
  input  logic [N_IN*W-1:0]    din,
  input  logic                 din_en,
  output logic [N_OUT*W-1:0]   dout,
  output logic                 dout_en
);

  logic [N_OUT*W-1:0] sum_c;
  logic               load;

  // A beat coinciding with sclr is dropped, so it never qualifies as valid.
  assign load = din_en & ~sclr;

  for (genvar j = 0; j < N_OUT; j++) begin : gen_pair
    if (2*j + 1 < N_IN) begin : g_add
      assign sum_c[j*W +: W] = din[2*j*W +: W] + din[(2*j+1)*W +: W];
    end else begin : g_pass
      assign sum_c[j*W +: W] = din[2*j*W +: W];
    end
  end

  if (REG != 0) begin : g_reg
    // Stage register: data loads only with a valid beat, valid follows the beat.
    always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
        dout    <= '0;
        dout_en <= 1'b0;
      end else begin
        dout_en <= load;
        if (load) dout <= sum_c;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, areset};
    assign dout    = sum_c;
    assign dout_en = load;
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined balanced adder tree over NB_IN words with a travelling valid strobe.
// Optional accumulator over ACC_LEN tree results is built when the macro
// ADDER_TREE_ACC_EN is defined; without it the block is the pipelined tree only.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int NB_IN       = 8,
  parameter int IN_WIDTH    = 16,
  parameter int SIGNED      = 0,
  parameter int PIPE_STRIDE = 1,
  parameter int ACC_LEN     = 16
) (
  input  logic                                clk,
  input  logic                                areset,
  input  logic                                sclr,
  input  logic [IN_WIDTH-1:0]                 data_in [NB_IN],
  input  logic                                data_in_en,
  output logic [IN_WIDTH+$clog2(NB_IN)-1:0]   data_out,
  output logic                                data_out_en
`ifdef ADDER_TREE_ACC_EN
  ,
  output logic [IN_WIDTH+$clog2(NB_IN)+$clog2(ACC_LEN)-1:0] acc_out,
  output logic                                acc_out_en
`endif
);

  localparam int LEVELS    = clog2_min1(NB_IN);
  localparam int OUT_WIDTH = IN_WIDTH + $clog2(NB_IN);

  logic [NB_IN*OUT_WIDTH-1:0] ext_vec;

  // Widen every input to full precision up front so no level can overflow.
  for (genvar i = 0; i < NB_IN; i++) begin : gen_ext
    if (SIGNED != 0) begin : g_sx
      assign ext_vec[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'($signed(data_in[i]));
    end else begin : g_zx
      assign ext_vec[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(data_in[i]);
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : gen_lvl
    localparam int N_IN  = words_at_level(NB_IN, k - 1);
    localparam int N_OUT = words_at_level(NB_IN, k);
    localparam int REG   = level_is_reg(k, PIPE_STRIDE, LEVELS) ? 1 : 0;

    logic [N_OUT*OUT_WIDTH-1:0] sum_vec;
    logic                       sum_en;

    if (k == 1) begin : g_first
      adder_tree_level #(
        .N_IN (N_IN),
        .W    (OUT_WIDTH),
        .REG  (REG),
        .N_OUT(N_OUT)
      ) u_level (
        .clk    (clk),
        .areset (areset),
        .sclr   (sclr),
        .din    (ext_vec),
        .din_en (data_in_en),
        .dout   (sum_vec),
        .dout_en(sum_en)
      );
    end else begin : g_next
      adder_tree_level #(
        .N_IN (N_IN),
        .W    (OUT_WIDTH),
        .REG  (REG),
        .N_OUT(N_OUT)
      ) u_level (
        .clk    (clk),
        .areset (areset),
        .sclr   (sclr),
        .din    (gen_lvl[k-1].sum_vec),
        .din_en (gen_lvl[k-1].sum_en),
        .dout   (sum_vec),
        .dout_en(sum_en)
      );
    end
  end

  // The last level is always registered, so these are register outputs.
  assign data_out    = gen_lvl[LEVELS].sum_vec;
  assign data_out_en = gen_lvl[LEVELS].sum_en;

`ifdef ADDER_TREE_ACC_EN
  localparam int ACC_WIDTH = OUT_WIDTH + $clog2(ACC_LEN);
  localparam int CNT_WIDTH = clog2_min1(ACC_LEN);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] data_ext;
  logic [CNT_WIDTH-1:0] acc_cnt;

  if (SIGNED != 0) begin : g_acc_sx
    assign data_ext = ACC_WIDTH'($signed(data_out));
  end else begin : g_acc_zx
    assign data_ext = ACC_WIDTH'(data_out);
  end

  // Sum ACC_LEN tree results, publish on the last one and restart in the same cycle.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      acc        <= '0;
      acc_cnt    <= '0;
      acc_out    <= '0;
      acc_out_en <= 1'b0;
    end else if (sclr) begin
      acc        <= '0;
      acc_cnt    <= '0;
      acc_out_en <= 1'b0;
    end else begin
      acc_out_en <= 1'b0;
      if (data_out_en) begin
        if (acc_cnt == CNT_WIDTH'(ACC_LEN - 1)) begin
          acc_out    <= acc + data_ext;
          acc_out_en <= 1'b1;
          acc        <= '0;
          acc_cnt    <= '0;
        end else begin
          acc     <= acc + data_ext;
          acc_cnt <= acc_cnt + 1'b1;
        end
      end
    end
  end
`else
  localparam int unused_acc_len = ACC_LEN;
`endif

endmodule
